// File: rtl/vector_memory_stage.sv
// Memory stage: serialises scalar/vector loads and stores onto a byte-wide synchronous
// memory port one lane per cycle, stalling upstream while a multi-beat access runs.
module vector_memory_stage #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned VECTOR_SIZE = 6
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              valid,
   input  logic                              memRead,
   input  logic                              memWrite,
   input  logic                              isScalar,
   input  logic [DATA_WIDTH-1:0]             address,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] storeData,
   input  logic [DATA_WIDTH-1:0]             memRData,
   output logic [DATA_WIDTH-1:0]             memAddr,
   output logic [DATA_WIDTH-1:0]             memWData,
   output logic                              memWE,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0] readData,
   output logic                              loadDone,
   output logic                              stall,
   output logic                              busy
);

   localparam int unsigned KW = $clog2(VECTOR_SIZE + 1);
   localparam int unsigned VW = DATA_WIDTH * VECTOR_SIZE;

   typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

   state_e              state_q, state_d;
   logic [KW-1:0]       k_q, k_d, n_q, n_d;
   logic [VW-1:0]       acc_q, acc_d, rd_q, rd_d;
   logic [VW-1:0]       done_vec;
   logic [DATA_WIDTH-1:0] addr_k, addr_c, wdata_c, lane_k;
   logic                we_c, stall_c, done_c;

   assign addr_k = address + DATA_WIDTH'(k_q);

   always_comb begin
      lane_k   = '0;
      done_vec = '0;
      for (int j = 0; j < int'(VECTOR_SIZE); j++) begin
         if (KW'(j) == k_q) lane_k = storeData[j*DATA_WIDTH +: DATA_WIDTH];
         // Final-beat view: buffered lanes below N-1, live memory data in lane N-1, zeros above.
         if (KW'(j + 1) < n_q)       done_vec[j*DATA_WIDTH +: DATA_WIDTH] = acc_q[j*DATA_WIDTH +: DATA_WIDTH];
         else if (KW'(j + 1) == n_q) done_vec[j*DATA_WIDTH +: DATA_WIDTH] = memRData;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      n_d     = n_q;
      acc_d   = acc_q;
      rd_d    = rd_q;
      addr_c  = '0;
      wdata_c = '0;
      we_c    = 1'b0;
      stall_c = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (valid && memWrite) begin
               we_c    = 1'b1;
               addr_c  = address;
               wdata_c = storeData[DATA_WIDTH-1:0];
               n_d     = isScalar ? KW'(1) : KW'(VECTOR_SIZE);
               if (!isScalar) begin
                  stall_c = 1'b1;
                  state_d = StWrite;
                  k_d     = KW'(1);
               end
            end else if (valid && memRead) begin
               addr_c  = address;
               stall_c = 1'b1;
               n_d     = isScalar ? KW'(1) : KW'(VECTOR_SIZE);
               state_d = StRead;
               k_d     = KW'(1);
            end
         end
         StWrite: begin
            we_c    = 1'b1;
            addr_c  = addr_k;
            wdata_c = lane_k;
            if (k_q < n_q - KW'(1)) begin
               stall_c = 1'b1;
               k_d     = k_q + KW'(1);
            end else begin
               state_d = StIdle;
               k_d     = '0;
            end
         end
         StRead: begin
            for (int j = 0; j < int'(VECTOR_SIZE); j++) begin
               if (KW'(j + 1) == k_q) acc_d[j*DATA_WIDTH +: DATA_WIDTH] = memRData;
            end
            if (k_q < n_q) begin
               addr_c  = addr_k;
               stall_c = 1'b1;
               k_d     = k_q + KW'(1);
            end else begin
               addr_c  = address + DATA_WIDTH'(n_q - KW'(1));
               done_c  = 1'b1;
               rd_d    = done_vec;
               state_d = StIdle;
               k_d     = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= '0;
         n_q     <= '0;
         acc_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         rd_q    <= rd_d;
      end
   end

   // Outputs are forced low while reset is held so an abort is visible immediately.
   assign memAddr  = rst ? '0 : addr_c;
   assign memWData = rst ? '0 : wdata_c;
   assign memWE    = rst ? 1'b0 : we_c;
   assign stall    = rst ? 1'b0 : stall_c;
   assign loadDone = rst ? 1'b0 : done_c;
   assign busy     = rst ? 1'b0 : (state_q != StIdle);
   assign readData = rst ? '0 : (done_c ? done_vec : rd_q);

endmodule
